// File: rtl/mojo_com_sync.sv
// Coherency layer between mojo_com's free-running register arrays and the fountain logic:
// RX snapshot between SPI transactions, round-robin TX writers, double-buffered TX commit.
module mojo_com_sync #(
    parameter int ADDR_SPACE = 64,
    parameter int N_REQ      = 2,
    parameter int ADDR_BITS  = $clog2(ADDR_SPACE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8*ADDR_SPACE-1:0]    rx_arr,
    input  logic                       rx_busy,
    input  logic                       new_rx,
    input  logic                       tx_busy,
    output logic [8*ADDR_SPACE-1:0]    tx_arr,
    output logic [8*ADDR_SPACE-1:0]    rx_snap,
    output logic                       rx_update,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*ADDR_BITS-1:0] req_addr,
    input  logic [N_REQ*8-1:0]         req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx_pending,
    output logic                       rx_state_dbg
);
    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_DIRTY = 1'b1
    } rx_state_e;

    rx_state_e rx_state_q, rx_state_d;
    logic      capture;
    logic      rx_update_q;
    logic [8*ADDR_SPACE-1:0] rx_snap_q;
    logic [8*ADDR_SPACE-1:0] tx_work_q;
    logic [8*ADDR_SPACE-1:0] tx_arr_q;
    logic      tx_dirty_q, tx_dirty_d;
    logic [RR_W-1:0] rr_q, rr_d;

    logic            gnt_any;
    logic [RR_W-1:0] gnt_idx;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [7:0]      wr_data;
    logic            commit;

    // Wait until the SPI side has gone quiet (no busy, no fresh write) before copying.
    always_comb begin
        rx_state_d = rx_state_q;
        capture    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (new_rx) rx_state_d = RX_DIRTY;
            end
            RX_DIRTY: begin
                if (!rx_busy && !new_rx) begin
                    capture    = 1'b1;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Round robin: first pass searches from rr upward, second pass wraps to the bottom.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        wr_addr   = '0;
        wr_data   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_any && req_valid[i] && (i >= int'(rr_q))) begin
                gnt_any      = 1'b1;
                gnt_idx      = RR_W'(i);
                req_ready[i] = 1'b1;
                wr_addr      = req_addr[i*ADDR_BITS +: ADDR_BITS];
                wr_data      = req_data[i*8 +: 8];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_any && req_valid[i]) begin
                gnt_any      = 1'b1;
                gnt_idx      = RR_W'(i);
                req_ready[i] = 1'b1;
                wr_addr      = req_addr[i*ADDR_BITS +: ADDR_BITS];
                wr_data      = req_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_any) begin
            if (gnt_idx == RR_W'(N_REQ - 1)) rr_d = '0;
            else                             rr_d = gnt_idx + 1'b1;
        end
    end

    // A write landing on the commit cycle keeps dirty set so it goes out next time.
    always_comb begin
        commit     = tx_dirty_q && !tx_busy;
        tx_dirty_d = tx_dirty_q;
        if (gnt_any)     tx_dirty_d = 1'b1;
        else if (commit) tx_dirty_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            rx_update_q <= 1'b0;
            rx_snap_q   <= '0;
            tx_work_q   <= '0;
            tx_arr_q    <= '0;
            tx_dirty_q  <= 1'b0;
            rr_q        <= '0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_update_q <= capture;
            if (capture) rx_snap_q <= rx_arr;
            if (gnt_any) tx_work_q[{wr_addr, 3'b000} +: 8] <= wr_data;
            if (commit)  tx_arr_q <= tx_work_q;
            tx_dirty_q  <= tx_dirty_d;
            rr_q        <= rr_d;
        end
    end

    assign tx_arr       = tx_arr_q;
    assign rx_snap      = rx_snap_q;
    assign rx_update    = rx_update_q;
    assign tx_pending   = tx_dirty_q;
    assign rx_state_dbg = rx_state_q;
endmodule
